ysyx_22041071_if_stage: RTL and testbench

Instruction-fetch stage, directly upstream of decode. It holds the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready channel. It buffers the returned word into the IF/ID output slot (PC2/Ins1/valid2) under a valid/ready handshake with decode. It also applies redirects: jal targets from decode, and jalr/branch resolutions from execute. Wrong-path fetches are killed on flush.

---
 rtl/ysyx_22041071_if_stage.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22041071_if_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_if_stage.sv
// rtl/ysyx_22041071_if_stage.sv - instruction fetch stage with redirect and flush handling
//
// Holds the fetch PC, issues one instruction-memory request at a time and
// buffers the returned word into the IF/ID slot (PC2/Ins1/valid2).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (addr = pc)
//   imem_rsp_valid/data         single-cycle response pulse and instruction word
//   JPC_sel/JPC                 jal redirect from decode
//   ex_redir/ex_redir_pc        jalr/branch redirect from execute (wins over JPC_sel)
//   bubble                      decode flush; fetch parks until a redirect arrives
//   ready2/valid2/PC2/Ins1      IF/ID output slot handshake
module ysyx_22041071_if_stage #(
  parameter int                ADDR_W   = 64,
  parameter int                INS_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INS_W-1:0]  imem_rsp_data,
  input  logic              JPC_sel,
  input  logic [ADDR_W-1:0] JPC,
  input  logic              ex_redir,
  input  logic [ADDR_W-1:0] ex_redir_pc,
  input  logic              bubble,
  input  logic              ready2,
  output logic              valid2,
  output logic [ADDR_W-1:0] PC2,
  output logic [INS_W-1:0]  Ins1
);

  localparam logic [INS_W-1:0] NOP_INS = INS_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                valid2_q, valid2_d;
  logic [ADDR_W-1:0]   pc2_q, pc2_d;
  logic [INS_W-1:0]    ins1_q, ins1_d;
  logic                drop_q, drop_d;
  // Bubble seen while a request was in flight: park in STALL once it returns.
  logic                stall_pend_q, stall_pend_d;

  logic                redir;
  logic [ADDR_W-1:0]   redir_raw;
  logic [ADDR_W-1:0]   redir_tgt;
  logic                req_fire;
  logic                in_flight;

  assign redir     = ex_redir | JPC_sel;
  assign redir_raw = ex_redir ? ex_redir_pc : JPC;
  // No compressed instructions, so targets are always word aligned.
  assign redir_tgt = {redir_raw[ADDR_W-1:2], 2'b00};

  assign imem_req_valid = (state_q == S_REQ) && (!valid2_q || ready2) && !reset;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A request is still owed a response after this cycle: either we are waiting
  // and it has not come back yet, or one is being accepted right now.
  assign in_flight = ((state_q == S_WAIT) && !imem_rsp_valid) || req_fire;

  assign valid2 = valid2_q;
  assign PC2    = pc2_q;
  assign Ins1   = ins1_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    valid2_d     = valid2_q;
    pc2_d        = pc2_q;
    ins1_d       = ins1_q;
    drop_d       = drop_q;
    stall_pend_d = stall_pend_q;

    if (valid2_q && ready2) begin
      valid2_d = 1'b0;
    end

    if (redir) begin
      pc_d         = redir_tgt;
      valid2_d     = 1'b0;
      stall_pend_d = 1'b0;
      if (in_flight) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    end else if (bubble) begin
      valid2_d = 1'b0;
      if (in_flight) begin
        state_d      = S_WAIT;
        drop_d       = 1'b1;
        stall_pend_d = 1'b1;
      end else begin
        state_d      = S_STALL;
        drop_d       = 1'b0;
        stall_pend_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(4);
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d       = 1'b0;
              stall_pend_d = 1'b0;
              state_d      = stall_pend_q ? S_STALL : S_REQ;
            end else begin
              valid2_d = 1'b1;
              ins1_d   = imem_rsp_data;
              pc2_d    = req_pc_q;
              state_d  = S_REQ;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      valid2_q     <= 1'b0;
      pc2_q        <= RESET_PC;
      ins1_q       <= NOP_INS;
      drop_q       <= 1'b0;
      stall_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      valid2_q     <= valid2_d;
      pc2_q        <= pc2_d;
      ins1_q       <= ins1_d;
      drop_q       <= drop_d;
      stall_pend_q <= stall_pend_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_if_stage.sv
// tb/tb_ysyx_22041071_if_stage.sv - self-checking bench for ysyx_22041071_if_stage
module tb_ysyx_22041071_if_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        JPC_sel;
  logic [63:0] JPC;
  logic        ex_redir;
  logic [63:0] ex_redir_pc;
  logic        bubble;
  logic        ready2;
  logic        valid2;
  logic [63:0] PC2;
  logic [31:0] Ins1;

  always #5 clk = ~clk;

  ysyx_22041071_if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .JPC_sel        (JPC_sel),
    .JPC            (JPC),
    .ex_redir       (ex_redir),
    .ex_redir_pc    (ex_redir_pc),
    .bubble         (bubble),
    .ready2         (ready2),
    .valid2         (valid2),
    .PC2            (PC2),
    .Ins1           (Ins1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents: word at 0x80000000 is 0x00100093, then +1 per byte address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] - 32'h8000_0000 + 32'h0010_0093;
  endfunction

  // Observation logs filled by the compare process.
  logic [63:0] acc_log[$];
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_ins[$];
  int          dlv_cyc[$];
  logic        last_acc;
  logic [63:0] last_acc_addr;

  // Compare process: fetch model at the level of "next fetch address",
  // "next delivered PC", "outstanding request killed or not", "parked".
  initial begin
    logic [63:0] m_req_pc;
    logic [63:0] m_out_pc;
    logic [63:0] hold_pc;
    logic [31:0] hold_ins;
    logic [63:0] tgt;
    bit m_stalled, m_out, m_killed;
    bit exp_v2, exp_new, exp_hold, prev_rst, pv2, prdy2;
    bit redir, flush, good, exp_req, acc;
    int cyc;
    m_req_pc = RPC; m_out_pc = RPC; hold_pc = RPC; hold_ins = NOP;
    m_stalled = 0; m_out = 0; m_killed = 0;
    exp_v2 = 0; exp_new = 0; exp_hold = 0; prev_rst = 0; pv2 = 0; prdy2 = 0;
    cyc = 0; last_acc = 0; last_acc_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        chk("rst_valid2", valid2, 1'b0);
        chk("rst_pc2", PC2, RPC);
        chk("rst_ins1", Ins1, NOP);
      end
      if (reset) begin
        chk("req_in_reset", imem_req_valid, 1'b0);
        m_req_pc = RPC; m_out_pc = RPC;
        m_stalled = 0; m_out = 0; m_killed = 0;
        exp_v2 = 0; exp_new = 0; exp_hold = 0;
        prev_rst = 1; pv2 = 0; prdy2 = 0;
        last_acc = 0;
      end else begin
        prev_rst = 0;
        chk("valid2", valid2, exp_v2);
        if (exp_new) begin
          chk("dlv_pc2", PC2, m_out_pc);
          chk("dlv_ins1", Ins1, memf(m_out_pc));
          m_out_pc = m_out_pc + 64'd4;
        end
        if (exp_hold) begin
          chk("hold_pc2", PC2, hold_pc);
          chk("hold_ins1", Ins1, hold_ins);
        end
        if (valid2 && (!pv2 || prdy2)) begin
          dlv_pc.push_back(PC2);
          dlv_ins.push_back(Ins1);
          dlv_cyc.push_back(cyc);
        end
        exp_req = !m_stalled && !m_out && (!valid2 || ready2);
        chk("req_valid", imem_req_valid, exp_req);
        if (imem_req_valid) chk("req_addr", imem_addr, m_req_pc);
        acc = imem_req_valid && imem_req_ready;
        last_acc = acc;
        last_acc_addr = imem_addr;
        if (acc) acc_log.push_back(imem_addr);

        redir = ex_redir || JPC_sel;
        flush = redir || bubble;
        tgt = ex_redir ? ex_redir_pc : JPC;
        tgt[1:0] = 2'b00;
        good = 0;
        if (acc) begin
          m_out = 1; m_killed = flush;
          m_req_pc = m_req_pc + 64'd4;
        end else if (imem_rsp_valid) begin
          good = m_out && !m_killed && !flush;
          m_out = 0; m_killed = 0;
        end else if (flush && m_out) begin
          m_killed = 1;
        end
        exp_hold = valid2 && !ready2 && !flush;
        hold_pc  = PC2;
        hold_ins = Ins1;
        exp_v2   = exp_hold || good;
        exp_new  = good;
        if (redir) begin
          m_req_pc = tgt; m_out_pc = tgt; m_stalled = 0;
        end else if (bubble) begin
          m_stalled = 1;
        end
        pv2 = valid2; prdy2 = ready2;
      end
    end
  end

  // Memory responder state, advanced by tick().
  bit          pend;
  int          cnt;
  int          lat;
  logic [63:0] paddr;

  task automatic tick();
    @(posedge clk);
    #1;
    JPC_sel  = 1'b0;
    ex_redir = 1'b0;
    bubble   = 1'b0;
    if (last_acc) begin
      pend = 1; paddr = last_acc_addr; cnt = lat;
    end
    imem_rsp_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(paddr);
        pend = 0;
      end
    end
  endtask

  task automatic wait_acc(input int max);
    int n;
    bit ok;
    n = acc_log.size();
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (acc_log.size() > n) ok = 1;
    end
    chk("acc_timeout", ok, 1'b1);
  endtask

  task automatic wait_dlv(input int n, input int max);
    bit ok;
    ok = (dlv_pc.size() >= n);
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (dlv_pc.size() >= n) ok = 1;
    end
    chk("dlv_timeout", ok, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend = 0;
    imem_rsp_valid = 1'b0;
    repeat (2) tick();
    acc_log.delete(); dlv_pc.delete(); dlv_ins.delete(); dlv_cyc.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nd;
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    JPC_sel = 1'b0; JPC = '0; ex_redir = 1'b0; ex_redir_pc = '0; bubble = 1'b0;
    ready2 = 1'b1; pend = 0; cnt = 0; lat = 1; paddr = '0;

    // Straight-line fetch, 1-cycle memory.
    do_reset();
    wait_dlv(3, 30);
    chk("seq_acc0", acc_log[0], 64'h8000_0000);
    chk("seq_acc1", acc_log[1], 64'h8000_0004);
    chk("seq_acc2", acc_log[2], 64'h8000_0008);
    chk("seq_pc1", dlv_pc[1], 64'h8000_0004);
    chk("seq_pc2", dlv_pc[2], 64'h8000_0008);
    chk("seq_ins0", dlv_ins[0], 32'h0010_0093);
    chk("seq_ins2", dlv_ins[2], 32'h0010_009b);
    chk("seq_gap01", dlv_cyc[1] - dlv_cyc[0], 2);
    chk("seq_gap12", dlv_cyc[2] - dlv_cyc[1], 2);

    // Decode back-pressure holds the slot and blocks new requests.
    ready2 = 1'b0;
    do_reset();
    wait_dlv(1, 20);
    repeat (5) begin
      tick();
      chk("bp_valid2", valid2, 1'b1);
      chk("bp_pc2", PC2, 64'h8000_0000);
      chk("bp_ins1", Ins1, 32'h0010_0093);
    end
    chk("bp_no_req", acc_log.size(), 1);
    ready2 = 1'b1;

    // jal redirect while waiting: in-flight word is killed.
    lat = 2;
    wait_acc(20);
    n0 = acc_log.size();
    JPC_sel = 1'b1; JPC = 64'h8000_0100;
    tick();
    nd = dlv_pc.size();
    wait_dlv(nd + 1, 40);
    chk("jal_acc", acc_log[n0], 64'h8000_0100);
    chk("jal_pc2", dlv_pc[nd], 64'h8000_0100);
    chk("jal_ins1", dlv_ins[nd], 32'h0010_0193);

    // Execute redirect beats decode redirect.
    wait_acc(20);
    n0 = acc_log.size();
    ex_redir = 1'b1; ex_redir_pc = 64'h8000_0040;
    JPC_sel = 1'b1; JPC = 64'h8000_0200;
    tick();
    nd = dlv_pc.size();
    wait_dlv(nd + 1, 40);
    chk("prio_acc", acc_log[n0], 64'h8000_0040);
    chk("prio_pc2", dlv_pc[nd], 64'h8000_0040);

    // Bubble parks fetch until an execute redirect.
    wait_acc(20);
    n0 = acc_log.size();
    nd = dlv_pc.size();
    bubble = 1'b1;
    tick();
    repeat (10) tick();
    chk("stall_no_req", acc_log.size(), n0);
    chk("stall_no_dlv", dlv_pc.size(), nd);
    chk("stall_valid2", valid2, 1'b0);
    ex_redir = 1'b1; ex_redir_pc = 64'h8000_0014;
    tick();
    wait_dlv(nd + 1, 40);
    chk("resume_acc", acc_log[n0], 64'h8000_0014);
    chk("resume_pc2", dlv_pc[nd], 64'h8000_0014);

    // Misaligned jal target, landing in the response cycle.
    lat = 1;
    wait_acc(20);
    n0 = acc_log.size();
    JPC_sel = 1'b1; JPC = 64'h8000_0103;
    tick();
    nd = dlv_pc.size();
    wait_dlv(nd + 1, 40);
    chk("mis_acc", acc_log[n0], 64'h8000_0100);
    chk("mis_pc2", dlv_pc[nd], 64'h8000_0100);

    // Memory not ready: request held, then withdrawn by a redirect.
    imem_req_ready = 1'b0;
    repeat (3) tick();
    n0 = acc_log.size();
    JPC_sel = 1'b1; JPC = 64'h8000_0300;
    tick();
    imem_req_ready = 1'b1;
    nd = dlv_pc.size();
    wait_dlv(nd + 1, 40);
    chk("wd_acc", acc_log[n0], 64'h8000_0300);
    chk("wd_pc2", dlv_pc[nd], 64'h8000_0300);

    // Reset while a request is outstanding.
    lat = 2;
    wait_acc(20);
    reset = 1'b1; pend = 0; imem_rsp_valid = 1'b0;
    tick();
    chk("mrst_valid2", valid2, 1'b0);
    chk("mrst_pc2", PC2, RPC);
    reset = 1'b0;
    chk("mrst_addr", imem_addr, RPC);
    n0 = acc_log.size();
    wait_acc(20);
    chk("mrst_acc", acc_log[n0], 64'h8000_0000);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
